// File: rtl/unidade_controle_sequencia_pkg.sv
// unidade_controle_sequencia_pkg: state codes and output decode shared by the game control unit
// and the datapath debug decoder.
package unidade_controle_sequencia_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        EXIBE_INICIAL  = 4'h2,
        INICIA_RODADA  = 4'h3,
        ESPERA_JOGADA  = 4'h4,
        REGISTRA       = 4'h5,
        COMPARA        = 4'h6,
        PROXIMO        = 4'h7,
        AVANCA_NOVA    = 4'h8,
        ESPERA_NOVA    = 4'h9,
        GRAVA_JOGADA   = 4'hA,
        AUMENTA_LIMITE = 4'hB,
        VERIFICA_FIM   = 4'hC,
        FINAL_ACERTO   = 4'hD,
        FINAL_ERRO     = 4'hE,
        FINAL_TIMEOUT  = 4'hF
    } estado_t;

    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_l;
        logic conta_l;
        logic zera_r;
        logic registra_r;
        logic zera_m;
        logic conta_m;
        logic registra_conf;
        logic exibe;
        logic escreve_m;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic timeout;
    } saidas_t;

    function automatic saidas_t decodifica(estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            PREPARACAO: begin
                s.zera_e        = 1'b1;
                s.zera_l        = 1'b1;
                s.zera_r        = 1'b1;
                s.zera_m        = 1'b1;
                s.registra_conf = 1'b1;
            end
            EXIBE_INICIAL: begin
                s.exibe   = 1'b1;
                s.conta_m = 1'b1;
            end
            INICIA_RODADA: begin
                s.zera_e = 1'b1;
                s.zera_m = 1'b1;
            end
            ESPERA_JOGADA, ESPERA_NOVA: s.conta_m = 1'b1;
            REGISTRA: begin
                s.registra_r = 1'b1;
                s.zera_m     = 1'b1;
            end
            PROXIMO, AVANCA_NOVA: s.conta_e = 1'b1;
            GRAVA_JOGADA: begin
                s.registra_r = 1'b1;
                s.escreve_m  = 1'b1;
                s.zera_m     = 1'b1;
            end
            AUMENTA_LIMITE: s.conta_l = 1'b1;
            FINAL_ACERTO: begin
                s.pronto = 1'b1;
                s.ganhou = 1'b1;
            end
            FINAL_ERRO: begin
                s.pronto = 1'b1;
                s.perdeu = 1'b1;
            end
            FINAL_TIMEOUT: begin
                s.pronto  = 1'b1;
                s.timeout = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_sequencia.sv
// unidade_controle_sequencia: Moore control FSM for the sequence memory game.
// Outputs are registered from the next state so they line up exactly with the state register.
module unidade_controle_sequencia
    import unidade_controle_sequencia_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_endereco,
    input  logic       fim_total,
    input  logic       fim_exibe,
    input  logic       fim_timeout,
    input  logic       timeout_hab,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraM,
    output logic       contaM,
    output logic       registraConf,
    output logic       exibe,
    output logic       escreveM,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado, nxt;
    saidas_t s;
    logic    expira;

    assign expira = fim_timeout && timeout_hab;

    always_comb begin
        nxt = estado;
        case (estado)
            INICIAL:        nxt = jogar ? PREPARACAO : INICIAL;
            PREPARACAO:     nxt = EXIBE_INICIAL;
            EXIBE_INICIAL:  nxt = fim_exibe ? INICIA_RODADA : EXIBE_INICIAL;
            INICIA_RODADA:  nxt = ESPERA_JOGADA;
            ESPERA_JOGADA:  nxt = jogada ? REGISTRA : expira ? FINAL_TIMEOUT : ESPERA_JOGADA;
            REGISTRA:       nxt = COMPARA;
            COMPARA:        nxt = !igual ? FINAL_ERRO : fim_endereco ? AVANCA_NOVA : PROXIMO;
            PROXIMO:        nxt = ESPERA_JOGADA;
            AVANCA_NOVA:    nxt = ESPERA_NOVA;
            ESPERA_NOVA:    nxt = jogada ? GRAVA_JOGADA : expira ? FINAL_TIMEOUT : ESPERA_NOVA;
            GRAVA_JOGADA:   nxt = AUMENTA_LIMITE;
            AUMENTA_LIMITE: nxt = VERIFICA_FIM;
            VERIFICA_FIM:   nxt = fim_total ? FINAL_ACERTO : INICIA_RODADA;
            FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT: nxt = jogar ? PREPARACAO : estado;
            default:        nxt = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
            s      <= '0;
        end else begin
            estado <= nxt;
            s      <= decodifica(nxt);
        end
    end

    assign {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraM, contaM,
            registraConf, exibe, escreveM, pronto, ganhou, perdeu, timeout} = s;
    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_sequencia.sv
// tb_unidade_controle_sequencia: directed game scenarios with a queue of expected states,
// each popped and compared one step after the stimulus that should produce it.
module tb_unidade_controle_sequencia;

    logic clock = 1'b0;
    logic reset, jogar, jogada, igual, fim_endereco, fim_total, fim_exibe, fim_timeout, timeout_hab;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraM, contaM;
    logic registraConf, exibe, escreveM, pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;
    int n_escreve = 0;
    int n_conta_l = 0;
    int n_conf    = 0;
    logic [3:0] exp_q[$];

    unidade_controle_sequencia dut (
        .clock(clock), .reset(reset), .jogar(jogar), .jogada(jogada), .igual(igual),
        .fim_endereco(fim_endereco), .fim_total(fim_total), .fim_exibe(fim_exibe),
        .fim_timeout(fim_timeout), .timeout_hab(timeout_hab),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL), .zeraR(zeraR),
        .registraR(registraR), .zeraM(zeraM), .contaM(contaM), .registraConf(registraConf),
        .exibe(exibe), .escreveM(escreveM), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Expected Moore outputs straight from the per-state output list.
    function automatic logic [14:0] eo(input logic [3:0] e);
        return {e == 4'h1 || e == 4'h3,
                e == 4'h7 || e == 4'h8,
                e == 4'h1,
                e == 4'hB,
                e == 4'h1,
                e == 4'h5 || e == 4'hA,
                e == 4'h1 || e == 4'h3 || e == 4'h5 || e == 4'hA,
                e == 4'h2 || e == 4'h4 || e == 4'h9,
                e == 4'h1,
                e == 4'h2,
                e == 4'hA,
                e >= 4'hD,
                e == 4'hD,
                e == 4'hE,
                e == 4'hF};
    endfunction

    task automatic chk();
        logic [3:0]  e;
        logic [14:0] o;
        o = {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraM, contaM,
             registraConf, exibe, escreveM, pronto, ganhou, perdeu, timeout};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL queue: empty, got state %0h", db_estado);
            return;
        end
        e = exp_q.pop_front();
        assert (db_estado === e) else begin
            bad++;
            $error("FAIL state: got %0h expected %0h", db_estado, e);
        end
        total++;
        assert (o === eo(e)) else begin
            bad++;
            $error("FAIL outputs in state %0h: got %b expected %b", e, o, eo(e));
        end
        n_escreve += int'(escreveM);
        n_conta_l += int'(contaL);
        n_conf    += int'(registraConf);
    endtask

    task automatic step(input logic [3:0] e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        chk();
    endtask

    task automatic count_check(input string tag, input int got, input int want);
        total++;
        assert (got == want) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Correct play; the last play of a round moves on to the new-play phase.
    task automatic acerto(input logic ultimo);
        jogada = 1'b1;
        step(4'h5);
        jogada = 1'b0;
        igual = 1'b1;
        fim_endereco = ultimo;
        step(4'h6);
        step(ultimo ? 4'h8 : 4'h7);
        igual = 1'b0;
        fim_endereco = 1'b0;
        step(ultimo ? 4'h9 : 4'h4);
    endtask

    task automatic nova(input logic acabou);
        jogada = 1'b1;
        step(4'hA);
        jogada = 1'b0;
        step(4'hB);
        step(4'hC);
        fim_total = acabou;
        step(acabou ? 4'hD : 4'h3);
        fim_total = 1'b0;
        if (!acabou) step(4'h4);
    endtask

    task automatic reinicia();
        jogar = 1'b1;
        step(4'h1);
        jogar = 1'b0;
        step(4'h2);
        fim_exibe = 1'b1;
        step(4'h3);
        fim_exibe = 1'b0;
        step(4'h4);
    endtask

    initial begin
        {jogar, jogada, igual, fim_endereco, fim_total, fim_exibe, fim_timeout, timeout_hab} = '0;
        reset = 1'b1;
        step(4'h0);
        step(4'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(4'h0);

        // Start: jogar held 5 cycles, display timer expires after 2000 cycles.
        n_conf = 0;
        jogar = 1'b1;
        step(4'h1);
        for (int i = 0; i < 4; i++) step(4'h2);
        jogar = 1'b0;
        for (int i = 0; i < 1996; i++) step(4'h2);
        fim_exibe = 1'b1;
        step(4'h3);
        fim_exibe = 1'b0;
        step(4'h4);
        count_check("registraConf pulses", n_conf, 1);

        // Full winning game: four rounds, one new play per round.
        n_escreve = 0;
        n_conta_l = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i <= r; i++) acerto(i == r);
            nova(r == 3);
        end
        step(4'hD);
        count_check("escreveM pulses", n_escreve, 4);
        count_check("contaL pulses", n_conta_l, 4);
        reinicia();

        // Loss in round 2 on the second play.
        acerto(1'b1);
        nova(1'b0);
        acerto(1'b0);
        jogada = 1'b1;
        step(4'h5);
        jogada = 1'b0;
        igual = 1'b0;
        step(4'h6);
        step(4'hE);
        step(4'hE);
        reinicia();

        // Timeout handling in espera_jogada.
        fim_timeout = 1'b1;
        timeout_hab = 1'b0;
        step(4'h4);
        step(4'h4);
        timeout_hab = 1'b1;
        jogada = 1'b1;
        step(4'h5);
        jogada = 1'b0;
        fim_timeout = 1'b0;
        igual = 1'b1;
        step(4'h6);
        step(4'h7);
        igual = 1'b0;
        step(4'h4);
        fim_timeout = 1'b1;
        step(4'hF);
        fim_timeout = 1'b0;
        step(4'hF);
        timeout_hab = 1'b0;
        reinicia();

        // Reset in espera_nova, then a clean restart.
        acerto(1'b1);
        step(4'h9);
        reset = 1'b1;
        step(4'h0);
        reset = 1'b0;
        step(4'h0);
        reinicia();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
